surf_hessian_det: RTL and testbench

Parametrised determinant-of-Hessian engine for the SURF detector datapath. It streams `Count` pixels of box-filter responses (Dxx, Dyy, Dxy) from synchronous SRAM read ports and computes det = Dxx·Dyy − w²·Dxy² with a programmable weight. Each result is written to an output SRAM, and the block tracks the strongest response and the count of responses above a threshold. It replaces the fixed single-result determinant core behind the `Go`/`Done` handshake in the SURF top level.

---
 rtl/surf_pkg.sv | 41 ++++
 rtl/surf_hessian_det_if.sv | 49 ++++
 rtl/surf_hessian_det_pipe.sv | 103 ++++++++++
 rtl/surf_hessian_det.sv | 159 +++++++++++++++
 tb/tb_surf_hessian_det.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/surf_pkg.sv
// ============================================================================
// Module   : surf_pkg
// Brief    : Shared constants, FSM encoding and saturation helper for the
//            SURF determinant-of-Hessian engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package surf_pkg;

    localparam int unsigned c_default_d_width   = 16;
    localparam int unsigned c_default_a_width   = 15;
    localparam int unsigned c_default_out_width = 32;
    // 0.81 in unsigned Q0.8
    localparam int unsigned c_w2_q8_0p81        = 207;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } surf_state_t;

    // Clip a signed value to the range of a WIDTH-bit two's complement word.
    function automatic longint surf_sat(input longint value, input int unsigned width);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/surf_hessian_det_if.sv
// ============================================================================
// Module   : surf_hessian_det_if
// Brief    : Control, SRAM read/write and status bundle of surf_hessian_det.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface surf_hessian_det_if #(
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned A_WIDTH   = 15,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                        Go;
    logic [A_WIDTH-1:0]          Start_Addr;
    logic [A_WIDTH:0]            Count;
    logic signed [OUT_WIDTH-1:0] Thresh;

    logic [A_WIDTH-1:0]          Rd_Addr;
    logic                        Rd_En;
    logic signed [D_WIDTH-1:0]   Dxx_Data;
    logic signed [D_WIDTH-1:0]   Dyy_Data;
    logic signed [D_WIDTH-1:0]   Dxy_Data;

    logic [A_WIDTH-1:0]          Wr_Addr;
    logic signed [OUT_WIDTH-1:0] Wr_Data;
    logic                        Wr_En;

    logic                        Busy;
    logic                        Done;
    logic signed [OUT_WIDTH-1:0] Max_Det;
    logic [A_WIDTH-1:0]          Max_Addr;
    logic [A_WIDTH:0]            Hit_Cnt;

    // Controller / SRAM side
    modport master (
        output Go, Start_Addr, Count, Thresh, Dxx_Data, Dyy_Data, Dxy_Data,
        input  Rd_Addr, Rd_En, Wr_Addr, Wr_Data, Wr_En,
        input  Busy, Done, Max_Det, Max_Addr, Hit_Cnt
    );

    // Engine side
    modport slave (
        input  Go, Start_Addr, Count, Thresh, Dxx_Data, Dyy_Data, Dxy_Data,
        output Rd_Addr, Rd_En, Wr_Addr, Wr_Data, Wr_En,
        output Busy, Done, Max_Det, Max_Addr, Hit_Cnt
    );
endinterface

`default_nettype wire

// File: rtl/surf_hessian_det_pipe.sv
// ============================================================================
// Module   : surf_det_pipe
// Brief    : Three-stage det = Dxx*Dyy - w^2*Dxy^2 datapath with saturation,
//            optional negative clamp and a valid/address sideband.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module surf_det_pipe
    import surf_pkg::*;
#(
    parameter int unsigned D_WIDTH   = c_default_d_width,
    parameter int unsigned A_WIDTH   = c_default_a_width,
    parameter int unsigned OUT_WIDTH = c_default_out_width,
    parameter int unsigned W2_Q8     = c_w2_q8_0p81,
    parameter bit          CLAMP_NEG = 1'b1
) (
    input  wire logic                        Clk,
    input  wire logic                        Rst,
    input  wire logic                        i_valid,
    input  wire logic [A_WIDTH-1:0]          i_addr,
    input  wire logic signed [D_WIDTH-1:0]   i_dxx,
    input  wire logic signed [D_WIDTH-1:0]   i_dyy,
    input  wire logic signed [D_WIDTH-1:0]   i_dxy,
    output logic                             o_valid,
    output logic [A_WIDTH-1:0]               o_addr,
    output logic signed [OUT_WIDTH-1:0]      o_det
);

    localparam int unsigned c_pw = 2 * D_WIDTH;
    localparam logic [c_pw+7:0] c_w2 = (c_pw + 8)'(W2_Q8);

    // S1 aligns the sideband with the SRAM data returning one cycle after the read
    logic                  r_s1_valid;
    logic [A_WIDTH-1:0]    r_s1_addr;

    logic                  r_s2_valid;
    logic [A_WIDTH-1:0]    r_s2_addr;
    logic signed [c_pw-1:0] r_p;
    logic [c_pw-1:0]       r_q;

    logic                  r_s3_valid;
    logic [A_WIDTH-1:0]    r_s3_addr;
    logic signed [OUT_WIDTH-1:0] r_det;

    logic signed [c_pw-1:0] w_p;
    logic signed [c_pw-1:0] w_sq;
    logic [c_pw-1:0]       w_sq_u;
    logic [c_pw+7:0]       w_wq;
    logic [c_pw-1:0]       w_q;
    logic signed [c_pw:0]  w_det;
    longint                w_sat;
    longint                w_fin;

    always_comb begin
        w_p    = i_dxx * i_dyy;
        w_sq   = i_dxy * i_dxy;
        w_sq_u = w_sq;
        w_wq   = {8'd0, w_sq_u} * c_w2;
        w_q    = c_pw'(w_wq >> 8);
        w_det  = $signed({r_p[c_pw-1], r_p}) - $signed({1'b0, r_q});
        w_sat  = surf_sat(longint'(w_det), OUT_WIDTH);
        w_fin  = w_sat;
        if (CLAMP_NEG && (w_sat < 64'sd0)) begin
            w_fin = 64'sd0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_s3_valid <= 1'b0;
            r_s3_addr  <= '0;
            r_det      <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_addr  <= i_addr;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_p       <= w_p;
                r_q       <= w_q;
            end
            if (r_s2_valid) begin
                r_s3_addr <= r_s2_addr;
                r_det     <= OUT_WIDTH'(w_fin);
            end
        end
    end

    assign o_valid = r_s3_valid;
    assign o_addr  = r_s3_addr;
    assign o_det   = r_det;

endmodule

`default_nettype wire

// File: rtl/surf_hessian_det.sv
// ============================================================================
// Module   : surf_hessian_det
// Brief    : Streaming determinant-of-Hessian engine: run FSM, read address
//            generator, strongest-response tracker and threshold hit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module surf_hessian_det
    import surf_pkg::*;
#(
    parameter int unsigned D_WIDTH   = c_default_d_width,
    parameter int unsigned A_WIDTH   = c_default_a_width,
    parameter int unsigned OUT_WIDTH = c_default_out_width,
    parameter int unsigned W2_Q8     = c_w2_q8_0p81,
    parameter bit          CLAMP_NEG = 1'b1
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    surf_hessian_det_if.slave  bus
);

    localparam logic [A_WIDTH:0] c_one_count = (A_WIDTH + 1)'(1);
    localparam logic signed [OUT_WIDTH-1:0] c_max_floor =
        CLAMP_NEG ? '0 : {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    surf_state_t                 r_state;
    surf_state_t                 w_next_state;
    logic [A_WIDTH-1:0]          r_rd_addr;
    logic [A_WIDTH:0]            r_remaining;
    logic [1:0]                  r_drain;
    logic signed [OUT_WIDTH-1:0] r_thresh;
    logic signed [OUT_WIDTH-1:0] r_max_det;
    logic [A_WIDTH-1:0]          r_max_addr;
    logic [A_WIDTH:0]            r_hit_cnt;

    logic                        w_accept;
    logic                        w_rd_en;
    logic                        w_busy;
    logic                        w_done;
    logic                        w_wr_en;
    logic [A_WIDTH-1:0]          w_wr_addr;
    logic signed [OUT_WIDTH-1:0] w_wr_data;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_en      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Go) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.Count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (r_remaining == c_one_count) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                // Third DRAIN cycle carries the final write of the run
                if (r_drain == 2'd2) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_drain     <= '0;
            r_thresh    <= '0;
            r_max_det   <= '0;
            r_max_addr  <= '0;
            r_hit_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Go) begin
                        r_rd_addr   <= bus.Start_Addr;
                        r_remaining <= bus.Count;
                        r_thresh    <= bus.Thresh;
                    end
                end
                ST_RUN: begin
                    r_rd_addr   <= r_rd_addr + A_WIDTH'(1);
                    r_remaining <= r_remaining - c_one_count;
                    r_drain     <= '0;
                end
                ST_DRAIN: r_drain <= r_drain + 2'd1;
                default: ;
            endcase

            if (w_accept) begin
                r_max_det  <= c_max_floor;
                r_max_addr <= '0;
                r_hit_cnt  <= '0;
            end else if (w_wr_en) begin
                // Strictly greater keeps the earliest address on ties
                if (w_wr_data > r_max_det) begin
                    r_max_det  <= w_wr_data;
                    r_max_addr <= w_wr_addr;
                end
                if ((w_wr_data > r_thresh) && (r_hit_cnt != '1)) begin
                    r_hit_cnt <= r_hit_cnt + c_one_count;
                end
            end
        end
    end

    surf_det_pipe #(
        .D_WIDTH   (D_WIDTH),
        .A_WIDTH   (A_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .W2_Q8     (W2_Q8),
        .CLAMP_NEG (CLAMP_NEG)
    ) u_pipe (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_valid (w_rd_en),
        .i_addr  (r_rd_addr),
        .i_dxx   (bus.Dxx_Data),
        .i_dyy   (bus.Dyy_Data),
        .i_dxy   (bus.Dxy_Data),
        .o_valid (w_wr_en),
        .o_addr  (w_wr_addr),
        .o_det   (w_wr_data)
    );

    assign bus.Rd_Addr  = r_rd_addr;
    assign bus.Rd_En    = w_rd_en;
    assign bus.Wr_Addr  = w_wr_addr;
    assign bus.Wr_Data  = w_wr_data;
    assign bus.Wr_En    = w_wr_en;
    assign bus.Busy     = w_busy;
    assign bus.Done     = w_done;
    assign bus.Max_Det  = r_max_det;
    assign bus.Max_Addr = r_max_addr;
    assign bus.Hit_Cnt  = r_hit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_surf_hessian_det.sv
// ============================================================================
// Module   : tb_surf_hessian_det
// Brief    : Self-checking bench: default build (32-bit, clamped) and a 16-bit
//            unclamped build driven with identical jobs against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_surf_hessian_det;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    surf_hessian_det_if #(.D_WIDTH(16), .A_WIDTH(15), .OUT_WIDTH(32)) ifa ();
    surf_hessian_det_if #(.D_WIDTH(16), .A_WIDTH(15), .OUT_WIDTH(16)) ifb ();

    surf_hessian_det #(
        .D_WIDTH(16), .A_WIDTH(15), .OUT_WIDTH(32), .W2_Q8(207), .CLAMP_NEG(1'b1)
    ) dut_a (
        .Clk (clk),
        .Rst (rst),
        .bus (ifa.slave)
    );

    surf_hessian_det #(
        .D_WIDTH(16), .A_WIDTH(15), .OUT_WIDTH(16), .W2_Q8(207), .CLAMP_NEG(1'b0)
    ) dut_b (
        .Clk (clk),
        .Rst (rst),
        .bus (ifb.slave)
    );

    logic signed [15:0] mem_dxx [32768];
    logic signed [15:0] mem_dyy [32768];
    logic signed [15:0] mem_dxy [32768];

    // Synchronous SRAM read ports: data valid the cycle after Rd_En
    always @(posedge clk) begin
        if (ifa.Rd_En) begin
            ifa.Dxx_Data <= mem_dxx[ifa.Rd_Addr];
            ifa.Dyy_Data <= mem_dyy[ifa.Rd_Addr];
            ifa.Dxy_Data <= mem_dxy[ifa.Rd_Addr];
        end
        if (ifb.Rd_En) begin
            ifb.Dxx_Data <= mem_dxx[ifb.Rd_Addr];
            ifb.Dyy_Data <= mem_dyy[ifb.Rd_Addr];
            ifb.Dxy_Data <= mem_dxy[ifb.Rd_Addr];
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_det(input longint dxx, input longint dyy,
                                       input longint dxy, input int ow, input bit clamp);
        longint d;
        longint hi;
        d  = dxx * dyy - (dxy * dxy * 207) / 256;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        if (d > hi)      d = hi;
        if (d < -hi - 1) d = -hi - 1;
        if (clamp && d < 0) d = 0;
        return d;
    endfunction

    task automatic drive_go(input bit go, input int start, input int n, input longint thr);
        ifa.Go = go;               ifb.Go = go;
        ifa.Start_Addr = 15'(start); ifb.Start_Addr = 15'(start);
        ifa.Count = 16'(n);        ifb.Count = 16'(n);
        ifa.Thresh = 32'(thr);     ifb.Thresh = 16'(thr);
    endtask

    task automatic load(input int a, input int dxx, input int dyy, input int dxy);
        mem_dxx[a % 32768] = 16'(dxx);
        mem_dyy[a % 32768] = 16'(dyy);
        mem_dxy[a % 32768] = 16'(dxy);
    endtask

    task automatic load_rand(input int start, input int n);
        for (int i = 0; i < n; i++)
            load(start + i, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    endtask

    task automatic check_dut(input string who, input int k, input int n, input int start,
                             input int done_k, input longint ewr, input longint emax,
                             input int eaddr, input int ehit,
                             input logic rd_en, input logic [14:0] rd_addr,
                             input logic wr_en, input logic [14:0] wr_addr,
                             input logic signed [63:0] wr_data, input logic busy,
                             input logic done, input logic signed [63:0] maxd,
                             input logic [14:0] maxa, input logic [15:0] hit);
        bit exp_rd;
        bit exp_wr;
        exp_rd = (k >= 1) && (k <= n);
        exp_wr = (n > 0) && (k >= 4) && (k <= n + 3);
        chk({who, ".rd_en"}, rd_en, exp_rd);
        if (exp_rd) chk({who, ".rd_addr"}, rd_addr, (start + k - 1) % 32768);
        chk({who, ".wr_en"}, wr_en, exp_wr);
        if (exp_wr) begin
            chk({who, ".wr_addr"}, wr_addr, (start + k - 4) % 32768);
            chk({who, ".wr_data"}, wr_data, ewr);
        end
        chk({who, ".done"}, done, k == done_k);
        chk({who, ".busy"}, busy, k <= done_k);
        if (k == done_k) begin
            chk({who, ".max_det"}, maxd, emax);
            chk({who, ".max_addr"}, maxa, eaddr);
            chk({who, ".hit_cnt"}, hit, ehit);
        end
    endtask

    // Go is issued, then every cycle through Done+1 is checked; a second Go
    // with different operands can be injected during the run at cycle go_again_at.
    task automatic run_job(input int start, input int n, input longint thr, input int go_again_at);
        longint ea[$];
        longint eb[$];
        longint amax = 0;
        longint bmax = -32768;
        int     aaddr = 0, baddr = 0, ahit = 0, bhit = 0;
        int     done_k;
        for (int i = 0; i < n; i++) begin
            int a;
            longint va, vb;
            a  = (start + i) % 32768;
            va = ref_det(mem_dxx[a], mem_dyy[a], mem_dxy[a], 32, 1'b1);
            vb = ref_det(mem_dxx[a], mem_dyy[a], mem_dxy[a], 16, 1'b0);
            ea.push_back(va);
            eb.push_back(vb);
            if (va > amax) begin amax = va; aaddr = a; end
            if (vb > bmax) begin bmax = vb; baddr = a; end
            if (va > thr) ahit++;
            if (vb > thr) bhit++;
        end
        done_k = (n == 0) ? 1 : n + 4;
        @(negedge clk);
        drive_go(1'b1, start, n, thr);
        for (int k = 1; k <= done_k + 1; k++) begin
            longint wa, wb;
            @(negedge clk);
            if (k == go_again_at) drive_go(1'b1, 5000, 3, -1);
            else                  ifa.Go = 1'b0;
            ifb.Go = ifa.Go;
            wa = (k >= 4 && k - 4 < n) ? ea[k-4] : 0;
            wb = (k >= 4 && k - 4 < n) ? eb[k-4] : 0;
            check_dut("A", k, n, start, done_k, wa, amax, aaddr, ahit,
                      ifa.Rd_En, ifa.Rd_Addr, ifa.Wr_En, ifa.Wr_Addr, ifa.Wr_Data,
                      ifa.Busy, ifa.Done, ifa.Max_Det, ifa.Max_Addr, ifa.Hit_Cnt);
            check_dut("B", k, n, start, done_k, wb, bmax, baddr, bhit,
                      ifb.Rd_En, ifb.Rd_Addr, ifb.Wr_En, ifb.Wr_Addr, ifb.Wr_Data,
                      ifb.Busy, ifb.Done, ifb.Max_Det, ifb.Max_Addr, ifb.Hit_Cnt);
        end
        drive_go(1'b0, start, n, thr);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".A.rd_en"},   ifa.Rd_En,   0);
        chk({tag, ".A.rd_addr"}, ifa.Rd_Addr, 0);
        chk({tag, ".A.wr_en"},   ifa.Wr_En,   0);
        chk({tag, ".A.wr_data"}, ifa.Wr_Data, 0);
        chk({tag, ".A.busy"},    ifa.Busy,    0);
        chk({tag, ".A.done"},    ifa.Done,    0);
        chk({tag, ".A.max_det"}, ifa.Max_Det, 0);
        chk({tag, ".A.hit_cnt"}, ifa.Hit_Cnt, 0);
        chk({tag, ".B.wr_en"},   ifb.Wr_En,   0);
        chk({tag, ".B.rd_en"},   ifb.Rd_En,   0);
        chk({tag, ".B.max_det"}, ifb.Max_Det, 0);
        chk({tag, ".B.max_addr"}, ifb.Max_Addr, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive_go(1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // Uniform pixels: equal results, tie keeps the first address
        for (int i = 0; i < 4; i++) load(10 + i, 100, 50, 10);
        run_job(10, 4, 0, 0);

        // Negative clamp and both saturation directions
        load(100, 1, 1, 100);
        load(101, -32768, -32768, 0);
        load(102, 32767, -32768, 0);
        load(103, -5, 7, 3);
        run_job(100, 4, -100, 0);

        // Address wrap at the top of the SRAM
        load_rand(32766, 4);
        run_job(32766, 4, longint'($urandom_range(0, 20000)) - 10000, 0);

        // Empty job
        run_job(50, 0, 0, 0);

        // Go during a run is ignored
        load_rand(300, 8);
        run_job(300, 8, 0, 3);

        for (int j = 0; j < 2; j++) begin
            int s;
            s = int'($urandom_range(0, 32767));
            load_rand(s, 20);
            run_job(s, 20, longint'($urandom_range(0, 20000)) - 10000, 0);
        end

        // Reset five cycles into a 16-pixel run
        load_rand(200, 16);
        @(negedge clk);
        drive_go(1'b1, 200, 16, 0);
        @(negedge clk);
        drive_go(1'b0, 200, 16, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_reset.A.wr_en", ifa.Wr_En, 0);
            chk("post_reset.B.wr_en", ifb.Wr_En, 0);
            chk("post_reset.A.rd_en", ifa.Rd_En, 0);
            chk("post_reset.A.busy",  ifa.Busy,  0);
        end

        load_rand(400, 2);
        run_job(400, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
